psx_poll_scheduler: RTL

- Frame-level controller for the PSX pad bus.
- Sequences a byte-level PSX transceiver (start/done handshake) through full poll frames on two pad ports that share psx_clk/cmd/data/ack and have separate attention lines.
- Validates each reply and commits pad state atomically to the game logic.

---
 rtl/psx_poll_scheduler_pkg.sv | 39 +++
 rtl/psx_poll_scheduler_frame_shadow.sv | 68 ++++++
 rtl/psx_poll_scheduler.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/psx_poll_scheduler_pkg.sv
// Shared constants, state encoding and command-byte helper for the PSX pad poll scheduler.
package psx_pkg;

  localparam logic [7:0] CMD_START   = 8'h01;
  localparam logic [7:0] CMD_POLL    = 8'h42;
  localparam logic [7:0] CMD_IDLE    = 8'h00;
  localparam logic [7:0] RX_PREAMBLE = 8'h5A;

  localparam logic [7:0] ID_DIGITAL  = 8'h41;
  localparam logic [7:0] ID_ANALOG   = 8'h73;

  localparam int FRAME_LEN_DIGITAL = 5;
  localparam int FRAME_LEN_ANALOG  = 9;
  localparam logic [3:0] LAST_IDX_DIGITAL = 4'(FRAME_LEN_DIGITAL - 1);
  localparam logic [3:0] LAST_IDX_ANALOG  = 4'(FRAME_LEN_ANALOG - 1);

  localparam logic [15:0] BUTTONS_IDLE   = 16'hFFFF;
  localparam logic [31:0] STICKS_NEUTRAL = 32'h8080_8080;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_WAIT_POLL,
    ST_ATT_SETUP,
    ST_SEND,
    ST_WAIT_BYTE,
    ST_ATT_HOLD
  } psx_state_t;

  function automatic logic [7:0] cmd_byte(input logic [3:0] idx);
    if (idx == 4'd0)      return CMD_START;
    else if (idx == 4'd1) return CMD_POLL;
    else                  return CMD_IDLE;
  endfunction

  function automatic logic id_valid(input logic [7:0] id);
    return (id == ID_DIGITAL) || (id == ID_ANALOG);
  endfunction

endpackage

// File: rtl/psx_poll_scheduler_frame_shadow.sv
// Per-port reply shadow: collects payload bytes mid-frame and moves them to the
// visible pad registers only on a good final byte, or neutralises them on abort.
module psx_frame_shadow
  import psx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        capture,
  input  logic [3:0]  idx,
  input  logic [7:0]  rx,
  input  logic        commit,
  input  logic        abort,
  input  logic        analog,
  output logic [15:0] buttons,
  output logic [31:0] sticks,
  output logic        present,
  output logic        is_analog
);

  logic [15:0] btn_sh, btn_nxt;
  logic [31:0] stk_sh, stk_nxt;

  // Commit reads the next-shadow so the final byte lands in the same cycle.
  always_comb begin
    btn_nxt = btn_sh;
    stk_nxt = stk_sh;
    if (capture) begin
      case (idx)
        4'd3:    btn_nxt[15:8]  = rx;
        4'd4:    btn_nxt[7:0]   = rx;
        4'd5:    stk_nxt[31:24] = rx;
        4'd6:    stk_nxt[23:16] = rx;
        4'd7:    stk_nxt[15:8]  = rx;
        4'd8:    stk_nxt[7:0]   = rx;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_sh <= BUTTONS_IDLE;
      stk_sh <= STICKS_NEUTRAL;
    end else begin
      btn_sh <= btn_nxt;
      stk_sh <= stk_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buttons   <= BUTTONS_IDLE;
      sticks    <= STICKS_NEUTRAL;
      present   <= 1'b0;
      is_analog <= 1'b0;
    end else if (commit) begin
      buttons   <= btn_nxt;
      sticks    <= analog ? stk_nxt : STICKS_NEUTRAL;
      present   <= 1'b1;
      is_analog <= analog;
    end else if (abort) begin
      buttons   <= BUTTONS_IDLE;
      sticks    <= STICKS_NEUTRAL;
      present   <= 1'b0;
    end
  end

endmodule

// File: rtl/psx_poll_scheduler.sv
// PSX pad frame controller: boots, polls both ports in pairs, validates replies, commits pad state.
// Optional rumble drive on idx3/idx4 is enabled by defining PSX_RUMBLE_EN.
module psx_poll_scheduler
  import psx_pkg::*;
#(
  parameter int unsigned BOOT_CYCLES  = 4000000,
  parameter int unsigned POLL_PERIOD  = 33333,
  parameter int unsigned ATT_SETUP    = 40,
  parameter int unsigned ATT_HOLD     = 30,
  parameter int unsigned XFER_TIMEOUT = 200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        poll_now,
  output logic [1:0]  att_n,
  output logic        xb_start,
  output logic [7:0]  xb_tx,
  input  logic        xb_done,
  input  logic [7:0]  xb_rx,
  input  logic        xb_ack,
  output logic [31:0] pad_buttons,
  output logic [63:0] pad_sticks,
  output logic [1:0]  pad_present,
  output logic [1:0]  pad_analog,
  output logic        frame_done,
  output logic        frame_ok,
  output logic        frame_port
`ifdef PSX_RUMBLE_EN
  ,
  input  logic [1:0]  motor_small,
  input  logic [15:0] motor_large
`endif
);

  localparam logic [31:0] BOOT_LAST  = 32'(BOOT_CYCLES - 1);
  localparam logic [31:0] POLL_LAST  = 32'(POLL_PERIOD - 1);
  localparam logic [31:0] SETUP_LAST = 32'(ATT_SETUP - 1);
  localparam logic [31:0] HOLD_LAST  = 32'(ATT_HOLD - 1);
  // SEND takes one cycle of the budget and the ATT_HOLD entry edge another.
  localparam logic [31:0] XFER_LAST  = 32'(XFER_TIMEOUT - 2);

  psx_state_t  state, state_nxt;
  logic [31:0] cnt, cnt_nxt;
  logic [31:0] poll_tmr;
  logic        port, port_nxt;
  logic [3:0]  idx, idx_nxt;
  logic [7:0]  id_q;
  logic        pend;
  logic        start_pair, load_id, byte_done;
  logic        frm_end, frm_ok, do_commit, do_abort;
  logic [3:0]  last_idx;
  logic [7:0]  tx_byte;

  assign last_idx  = (id_q == ID_ANALOG) ? LAST_IDX_ANALOG : LAST_IDX_DIGITAL;
  assign byte_done = (state == ST_WAIT_BYTE) && xb_done;
  assign load_id   = byte_done && (idx == 4'd1);
  assign xb_start  = (state == ST_SEND);

  always_comb begin
    att_n = 2'b11;
    if (state == ST_ATT_SETUP || state == ST_SEND || state == ST_WAIT_BYTE)
      att_n[port] = 1'b0;
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt + 32'd1;
    port_nxt   = port;
    idx_nxt    = idx;
    start_pair = 1'b0;
    frm_end    = 1'b0;
    frm_ok     = 1'b0;
    do_commit  = 1'b0;
    do_abort   = 1'b0;
    case (state)
      ST_BOOT: begin
        if (cnt == BOOT_LAST) begin
          state_nxt = ST_WAIT_POLL;
          cnt_nxt   = '0;
        end
      end
      ST_WAIT_POLL: begin
        cnt_nxt = '0;
        if ((enable && poll_tmr == POLL_LAST) || pend || poll_now) begin
          start_pair = 1'b1;
          state_nxt  = ST_ATT_SETUP;
          port_nxt   = 1'b0;
        end
      end
      ST_ATT_SETUP: begin
        if (cnt == SETUP_LAST) begin
          state_nxt = ST_SEND;
          idx_nxt   = '0;
          cnt_nxt   = '0;
        end
      end
      ST_SEND: begin
        state_nxt = ST_WAIT_BYTE;
        cnt_nxt   = '0;
      end
      ST_WAIT_BYTE: begin
        if (xb_done) begin
          cnt_nxt = '0;
          if (idx == 4'd1 && !id_valid(xb_rx))
            do_abort = 1'b1;
          else if (idx == 4'd2 && xb_rx != RX_PREAMBLE)
            do_abort = 1'b1;
          else if (idx >= 4'd2 && idx == last_idx)
            do_commit = 1'b1;
          else if (!xb_ack)
            do_abort = 1'b1;
          else begin
            idx_nxt   = idx + 4'd1;
            state_nxt = ST_SEND;
          end
        end else if (cnt == XFER_LAST) begin
          cnt_nxt  = '0;
          do_abort = 1'b1;
        end
        if (do_abort || do_commit) begin
          state_nxt = ST_ATT_HOLD;
          frm_end   = 1'b1;
          frm_ok    = do_commit;
        end
      end
      ST_ATT_HOLD: begin
        if (cnt == HOLD_LAST) begin
          cnt_nxt = '0;
          if (!port) begin
            port_nxt  = 1'b1;
            state_nxt = ST_ATT_SETUP;
          end else begin
            state_nxt = ST_WAIT_POLL;
          end
        end
      end
      default: begin
        state_nxt = ST_BOOT;
        cnt_nxt   = '0;
      end
    endcase
  end

`ifdef PSX_RUMBLE_EN
  logic       ms_q;
  logic [7:0] ml_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ms_q <= 1'b0;
      ml_q <= 8'h00;
    end else if (state_nxt == ST_ATT_SETUP && state != ST_ATT_SETUP) begin
      ms_q <= port_nxt ? motor_small[1] : motor_small[0];
      ml_q <= port_nxt ? motor_large[15:8] : motor_large[7:0];
    end
  end

  // Motor bytes only go to pads that identified as analog-capable.
  always_comb begin
    tx_byte = cmd_byte(idx_nxt);
    if (id_q == ID_ANALOG && idx_nxt == 4'd3) tx_byte = ms_q ? 8'hFF : 8'h00;
    if (id_q == ID_ANALOG && idx_nxt == 4'd4) tx_byte = ml_q;
  end
`else
  assign tx_byte = cmd_byte(idx_nxt);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_BOOT;
      cnt        <= '0;
      port       <= 1'b0;
      idx        <= '0;
      id_q       <= 8'h00;
      poll_tmr   <= '0;
      pend       <= 1'b0;
      xb_tx      <= 8'h00;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      frame_port <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      port       <= port_nxt;
      idx        <= idx_nxt;
      frame_done <= frm_end;
      frame_ok   <= frm_ok;
      if (frm_end) frame_port <= port;
      if (load_id) id_q <= xb_rx;
      if (state_nxt == ST_SEND) xb_tx <= tx_byte;
      // Parked at the limit through boot so an enabled scheduler polls right away.
      if (state == ST_BOOT)             poll_tmr <= POLL_LAST;
      else if (start_pair)              poll_tmr <= '0;
      else if (poll_tmr != POLL_LAST)   poll_tmr <= poll_tmr + 32'd1;
      if (start_pair)                         pend <= 1'b0;
      else if (poll_now && state != ST_BOOT)  pend <= 1'b1;
    end
  end

  logic [1:0][15:0] btn_v;
  logic [1:0][31:0] stk_v;
  logic [1:0]       prs_v, ana_v;

  for (genvar p = 0; p < 2; p++) begin : g_port
    psx_frame_shadow u_shadow (
      .clk       (clk),
      .rst_n     (rst_n),
      .capture   (byte_done && (port == 1'(p))),
      .idx       (idx),
      .rx        (xb_rx),
      .commit    (do_commit && (port == 1'(p))),
      .abort     (do_abort && (port == 1'(p))),
      .analog    (id_q == ID_ANALOG),
      .buttons   (btn_v[p]),
      .sticks    (stk_v[p]),
      .present   (prs_v[p]),
      .is_analog (ana_v[p])
    );
  end

  assign pad_buttons = btn_v;
  assign pad_sticks  = stk_v;
  assign pad_present = prs_v;
  assign pad_analog  = ana_v;

endmodule
